// File: rtl/add_reservation_station.sv
// Reservation station for the integer adder: holds issued add ops, snoops the CDB for
// operands, and dispatches one ready op at a time until its result is broadcast.
module add_reservation_station #(
   parameter int unsigned NUM_ENTRIES = 3,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TAG_W       = 4,
   parameter int unsigned TAG_BASE    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic [DATA_W-1:0] issue_vj,
   input  logic [DATA_W-1:0] issue_vk,
   input  logic [TAG_W-1:0]  issue_qj,
   input  logic [TAG_W-1:0]  issue_qk,
   output logic              issue_ready,
   output logic [TAG_W-1:0]  issue_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   output logic              start,
   output logic [DATA_W-1:0] SrcA,
   output logic [DATA_W-1:0] SrcB,
   output logic [TAG_W-1:0]  exec_tag
);

   localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

   function automatic logic [TAG_W-1:0] entry_tag(input logic [IDX_W-1:0] idx);
      return TAG_W'(TAG_BASE) + TAG_W'(idx);
   endfunction

   logic [NUM_ENTRIES-1:0] busy_q, busy_d, disp_q, disp_d, ready;
   logic [DATA_W-1:0]      vj_q [NUM_ENTRIES];
   logic [DATA_W-1:0]      vj_d [NUM_ENTRIES];
   logic [DATA_W-1:0]      vk_q [NUM_ENTRIES];
   logic [DATA_W-1:0]      vk_d [NUM_ENTRIES];
   logic [TAG_W-1:0]       qj_q [NUM_ENTRIES];
   logic [TAG_W-1:0]       qj_d [NUM_ENTRIES];
   logic [TAG_W-1:0]       qk_q [NUM_ENTRIES];
   logic [TAG_W-1:0]       qk_d [NUM_ENTRIES];

   logic              inflight_q, inflight_d;
   logic [IDX_W-1:0]  exec_idx_q, exec_idx_d;
   logic              start_q, start_d;
   logic [DATA_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d;
   logic [TAG_W-1:0]  exec_tag_q, exec_tag_d;

   logic             free_found, disp_found;
   logic [IDX_W-1:0] free_idx, disp_idx;
   logic             alloc, dispatch, complete, bypass_j, bypass_k;

   // Priority search on registered state only: a freed entry is not reused on its completion edge.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      disp_found = 1'b0;
      disp_idx   = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         ready[i] = busy_q[i] && !disp_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
         if (!busy_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (ready[i] && !disp_found) begin
            disp_found = 1'b1;
            disp_idx   = IDX_W'(i);
         end
      end
   end

   assign alloc    = issue_valid && free_found;
   assign dispatch = !inflight_q && disp_found;
   assign complete = cdb_valid && inflight_q && (cdb_tag == exec_tag_q);
   assign bypass_j = cdb_valid && (issue_qj != '0) && (issue_qj == cdb_tag);
   assign bypass_k = cdb_valid && (issue_qk != '0) && (issue_qk == cdb_tag);

   always_comb begin
      busy_d     = busy_q;
      disp_d     = disp_q;
      vj_d       = vj_q;
      vk_d       = vk_q;
      qj_d       = qj_q;
      qk_d       = qk_q;
      inflight_d = inflight_q;
      exec_idx_d = exec_idx_q;
      start_d    = 1'b0;
      src_a_d    = src_a_q;
      src_b_d    = src_b_q;
      exec_tag_d = exec_tag_q;

      if (complete) begin
         inflight_d         = 1'b0;
         busy_d[exec_idx_q] = 1'b0;
      end

      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (busy_q[i] && cdb_valid) begin
            if ((qj_q[i] != '0) && (qj_q[i] == cdb_tag)) begin
               vj_d[i] = cdb_data;
               qj_d[i] = '0;
            end
            if ((qk_q[i] != '0) && (qk_q[i] == cdb_tag)) begin
               vk_d[i] = cdb_data;
               qk_d[i] = '0;
            end
         end
      end

      if (dispatch) begin
         start_d          = 1'b1;
         src_a_d          = vj_q[disp_idx];
         src_b_d          = vk_q[disp_idx];
         exec_tag_d       = entry_tag(disp_idx);
         exec_idx_d       = disp_idx;
         disp_d[disp_idx] = 1'b1;
         inflight_d       = 1'b1;
      end

      // The allocated entry is never busy, so snoop and completion cannot touch it too.
      if (alloc) begin
         busy_d[free_idx] = 1'b1;
         disp_d[free_idx] = 1'b0;
         vj_d[free_idx]   = bypass_j ? cdb_data : issue_vj;
         vk_d[free_idx]   = bypass_k ? cdb_data : issue_vk;
         qj_d[free_idx]   = bypass_j ? '0 : issue_qj;
         qk_d[free_idx]   = bypass_k ? '0 : issue_qk;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q     <= '0;
         disp_q     <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            vj_q[i] <= '0;
            vk_q[i] <= '0;
            qj_q[i] <= '0;
            qk_q[i] <= '0;
         end
         inflight_q <= 1'b0;
         exec_idx_q <= '0;
         start_q    <= 1'b0;
         src_a_q    <= '0;
         src_b_q    <= '0;
         exec_tag_q <= '0;
      end else begin
         busy_q     <= busy_d;
         disp_q     <= disp_d;
         vj_q       <= vj_d;
         vk_q       <= vk_d;
         qj_q       <= qj_d;
         qk_q       <= qk_d;
         inflight_q <= inflight_d;
         exec_idx_q <= exec_idx_d;
         start_q    <= start_d;
         src_a_q    <= src_a_d;
         src_b_q    <= src_b_d;
         exec_tag_q <= exec_tag_d;
      end
   end

   assign issue_ready = free_found;
   assign issue_tag   = entry_tag(free_idx);
   assign start       = start_q;
   assign SrcA        = src_a_q;
   assign SrcB        = src_b_q;
   assign exec_tag    = exec_tag_q;

endmodule
